max_pool_acc: RTL

MAX_POOL_ACC -- requirements
Module: max_pool_acc

---
 rtl/max_pool_acc.sv | 111 +++++++++++
 1 files changed

// File: rtl/max_pool_acc.sv
// Streaming per-channel max pooling over windows of K samples, with an
// early-close flush and a single-entry result hold stage.
module max_pool_acc #(
  parameter int N      = 16,
  parameter int C      = 4,
  parameter int K      = 4,
  parameter int SIGNED = 1
) (
  input  logic           clk,
  input  logic           master_rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [C*N-1:0] in_data,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [C*N-1:0] out_data,
  output logic [7:0]     out_count
);

  typedef enum logic {ACC, HOLD} state_e;

  state_e         state_q, state_d;
  logic [7:0]     count_q, count_d;
  logic [C*N-1:0] acc_q, acc_d;
  logic [C*N-1:0] merged;
  logic [7:0]     count_inc;
  logic           accept;

  function automatic logic [N-1:0] lane_max(input logic [N-1:0] cur,
                                            input logic [N-1:0] smp);
    logic gt;
    if (SIGNED != 0) gt = $signed(smp) > $signed(cur);
    else             gt = smp > cur;
    return gt ? smp : cur;
  endfunction

  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + 8'd1;

  always_comb begin
    merged = '0;
    for (int c = 0; c < C; c++)
      merged[c*N +: N] = lane_max(acc_q[c*N +: N], in_data[c*N +: N]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      state_q <= ACC;
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

  // A flush closes the window only if it holds at least one sample,
  // counting a sample accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC: begin
        if ((accept && count_inc == 8'(K)) ||
            (flush && (accept || count_q != '0)))
          state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          acc_d   = (count_q == '0) ? in_data : merged;
          count_d = count_inc;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (accept) begin
            acc_d   = in_data;
            count_d = 8'd1;
          end else begin
            count_d = '0;
          end
        end
      end
      default: count_d = '0;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ACC) || out_ready;
    out_valid = (state_q == HOLD);
    out_data  = acc_q;
    out_count = count_q;
  end

endmodule
